// File: rtl/br_transfer_ctrl.sv
// Sequencer that moves WORDS matrix words between the 16-bit data memory and the
// br register bank: loads A/B from memory into br, stores C from br into memory.
module br_transfer_ctrl #(
  parameter int WORDS  = 13,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [15:0]       mem_wdata,
  output logic              done,
  output logic [5:0]        endereco,
  output logic [15:0]       data_in,
  input  logic [15:0]       data_out,
  output logic              busy,
  output logic              finished
);

  typedef enum logic [3:0] {
    IDLE, RADDR, RWAIT, LSET, LSTROBE, LHOLD,
    SSET, SSTROBE, SHOLD, SWRITE, FINISH
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);

  state_t              state_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   base_q;
  logic [3:0]          idx_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic                memWren_q;
  logic [15:0]         memWdata_q;
  logic                done_q;
  logic [5:0]          endereco_q;
  logic [15:0]         dataIn_q;
  logic                busy_q;
  logic                finished_q;

  logic [3:0]          idx_d;
  logic [ADDR_W-1:0]   curAddr_d;
  logic [ADDR_W-1:0]   nextAddr_d;

  // Address sums are ADDR_W wide so base+idx wraps around the memory naturally.
  always_comb begin
    idx_d      = idx_q + 4'd1;
    curAddr_d  = base_q + ADDR_W'(idx_q);
    nextAddr_d = base_q + ADDR_W'(idx_d);
  end

  // Outputs are loaded on the edge that enters the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= 2'd0;
      base_q     <= '0;
      idx_q      <= 4'd0;
      memAddr_q  <= '0;
      memWren_q  <= 1'b0;
      memWdata_q <= 16'd0;
      done_q     <= 1'b0;
      endereco_q <= 6'd0;
      dataIn_q   <= 16'd0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && op != 2'd3) begin
            op_q       <= op;
            base_q     <= base_addr;
            idx_q      <= 4'd0;
            endereco_q <= {op, 4'd0};
            busy_q     <= 1'b1;
            if (op == 2'd2) begin
              state_q <= SSET;
            end else begin
              memAddr_q <= base_addr;
              state_q   <= RADDR;
            end
          end
        end
        RADDR:   state_q <= RWAIT;
        RWAIT: begin
          dataIn_q <= mem_rdata;
          state_q  <= LSET;
        end
        LSET: begin
          done_q  <= 1'b1;
          state_q <= LSTROBE;
        end
        LSTROBE: begin
          done_q  <= 1'b0;
          state_q <= LHOLD;
        end
        LHOLD: begin
          if (idx_q == LAST_IDX) begin
            finished_q <= 1'b1;
            state_q    <= FINISH;
          end else begin
            idx_q      <= idx_d;
            memAddr_q  <= nextAddr_d;
            endereco_q <= {op_q, idx_d};
            state_q    <= RADDR;
          end
        end
        SSET: begin
          done_q  <= 1'b1;
          state_q <= SSTROBE;
        end
        SSTROBE: begin
          done_q  <= 1'b0;
          state_q <= SHOLD;
        end
        SHOLD: begin
          memAddr_q  <= curAddr_d;
          memWdata_q <= data_out;
          memWren_q  <= 1'b1;
          state_q    <= SWRITE;
        end
        SWRITE: begin
          memWren_q <= 1'b0;
          if (idx_q == LAST_IDX) begin
            finished_q <= 1'b1;
            state_q    <= FINISH;
          end else begin
            idx_q      <= idx_d;
            endereco_q <= {op_q, idx_d};
            state_q    <= SSET;
          end
        end
        FINISH: begin
          finished_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = memAddr_q;
  assign mem_wren  = memWren_q;
  assign mem_wdata = memWdata_q;
  assign done      = done_q;
  assign endereco  = endereco_q;
  assign data_in   = dataIn_q;
  assign busy      = busy_q;
  assign finished  = finished_q;

endmodule
